// File: rtl/mux_pkg.sv
// Shared constants and types for the word serializer that feeds the 8-to-1 mux.
// Bit order is chosen at build time:
//   MUX_SER_MSB_FIRST_EN undefined : sel runs 0 -> NUM_IN-1 (LSB first)
//   MUX_SER_MSB_FIRST_EN defined   : sel runs NUM_IN-1 -> 0 (MSB first)
package mux_pkg;

    localparam int unsigned NUM_IN = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

`ifdef MUX_SER_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] FIRST_SEL = SEL_W'(NUM_IN - 1);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(0);
`else
    localparam logic [SEL_W-1:0] FIRST_SEL = SEL_W'(0);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_IN - 1);
`endif

    // One step of sel toward LAST_SEL.
    function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s);
`ifdef MUX_SER_MSB_FIRST_EN
        return s - SEL_W'(1);
`else
        return s + SEL_W'(1);
`endif
    endfunction

endpackage

// File: rtl/mux_sel_counter.sv
// Mux select counter. Holds sel, walks it from FIRST_SEL to LAST_SEL one step
// per advance, and returns to FIRST_SEL at the end of a word or on load.
// Direction comes from mux_pkg (MUX_SER_MSB_FIRST_EN).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load_i      restart at FIRST_SEL (new word captured)
//   advance_i   a serial beat was accepted
//   sel_o       current select
//   is_last_o   sel_o is at LAST_SEL
module mux_sel_counter
    import mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             advance_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             is_last_o
);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    assign is_last_o = (sel_q == LAST_SEL);
    assign sel_o     = sel_q;

    // Never step past LAST_SEL: the final beat always wraps back to FIRST_SEL.
    always_comb begin
        sel_d = sel_q;
        if (load_i) begin
            sel_d = FIRST_SEL;
        end else if (advance_i) begin
            sel_d = is_last_o ? FIRST_SEL : sel_step(sel_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= FIRST_SEL;
        end else begin
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/mux_word_serializer.sv
// Parallel-to-serial front end for the 8-to-1 mux. Captures a word over a
// valid/ready handshake, drives it onto the mux data inputs, steps the select
// through every position and forwards the mux result as a serial stream.
// Build option: MUX_SER_MSB_FIRST_EN selects MSB-first order (default LSB first).
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   load_valid, load_ready, load_data  word input handshake
//   mux_in, sel                        drive the external mux
//   mux_out                            external mux result
//   ser_valid, ser_ready, ser_bit      serial output handshake
//   ser_last                           final bit of the current word
//   busy                               word in flight
module mux_word_serializer
    import mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [NUM_IN-1:0] load_data,
    output logic [NUM_IN-1:0] mux_in,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_bit,
    output logic              ser_last,
    output logic              busy
);

    state_e            state_q;
    state_e            state_d;
    logic [NUM_IN-1:0] mux_in_q;
    logic              is_last;
    logic              load_fire;
    logic              beat_fire;

    assign load_fire = load_valid && load_ready;
    assign beat_fire = ser_valid && ser_ready;
    assign mux_in    = mux_in_q;
    assign ser_bit   = mux_out;

    mux_sel_counter u_sel_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_fire),
        .advance_i (beat_fire),
        .sel_o     (sel),
        .is_last_o (is_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a word ends in IDLE unless a new one is taken on its last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_ready && is_last && !load_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: a word is only accepted when idle or on the accepted last beat.
    always_comb begin
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid  = 1'b1;
                busy       = 1'b1;
                ser_last   = is_last;
                load_ready = ser_ready && is_last;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    // Word register; held for the whole word, so stalls cannot disturb ser_bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_in_q <= '0;
        end else if (load_fire) begin
            mux_in_q <= load_data;
        end
    end

endmodule
